// File: rtl/pipe_prefix_adder.sv
// pipe_prefix_adder: pipelined Kogge-Stone adder/subtractor with valid/ready flow; define ADDER_SAT_EN for signed saturation
module pipe_prefix_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH:0]   c,
  output logic             cout,
  output logic             ovf
);
  localparam int LV = $clog2(WIDTH);
  localparam int SW = WIDTH + 3;
  function automatic logic reg_at(input int l);
    logic r;
    r = 1'b0;
    for (int j = 1; j < STAGES; j++) if (j * LV / STAGES == l) r = 1'b1;
    return r;
  endfunction
  logic             adv;
  logic [WIDTH-1:0] bb;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bb       = sub ? ~b : b;
  for (genvar l = 0; l <= LV; l++) begin : lv
    logic [WIDTH-1:0] g, p, gq, pq;
    logic [SW-1:0]    s, sq;
    logic             v, vq;
    if (l == 0) begin : init
      assign g = a & bb;
      assign p = a ^ bb;
      assign s = {sat, a[WIDTH-1], sub | cin, a ^ bb};
      assign v = in_valid;
    end else begin : pre
      localparam int D = 1 << (l - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : bt
        if (i >= D) begin : mrg
          assign g[i] = lv[l-1].gq[i] | (lv[l-1].pq[i] & lv[l-1].gq[i-D]);
          assign p[i] = lv[l-1].pq[i] & lv[l-1].pq[i-D];
        end else begin : pas
          assign g[i] = lv[l-1].gq[i];
          assign p[i] = lv[l-1].pq[i];
        end
      end
      assign s = lv[l-1].sq;
      assign v = lv[l-1].vq;
    end
    if (reg_at(l)) begin : r
      // internal pipeline register after this prefix level; payload only loads with a live transaction
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          vq <= 1'b0;
          gq <= '0;
          pq <= '0;
          sq <= '0;
        end else if (adv) begin
          vq <= v;
          if (v) {gq, pq, sq} <= {g, p, s};
        end
    end else begin : w
      assign gq = g;
      assign pq = p;
      assign sq = s;
      assign vq = v;
    end
  end
  logic             ci, of;
  logic [WIDTH:0]   cc;
  logic [WIDTH-1:0] wrapped, res;
  assign ci      = lv[LV].sq[WIDTH];
  assign cc      = {lv[LV].gq | (lv[LV].pq & {WIDTH{ci}}), ci};
  assign wrapped = lv[LV].sq[WIDTH-1:0] ^ cc[WIDTH-1:0];
  assign of      = cc[WIDTH] ^ cc[WIDTH-1];
`ifdef ADDER_SAT_EN
  assign res = (lv[LV].sq[WIDTH+2] && of) ?
               (lv[LV].sq[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : wrapped;
`else
  logic unused_sat;
  assign unused_sat = ^lv[LV].sq[WIDTH+2:WIDTH+1];
  assign res = wrapped;
`endif
  // output register: holds result while stalled, cleared immediately by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= lv[LV].vq;
      if (lv[LV].vq) begin
        sum  <= res;
        c    <= cc;
        cout <= cc[WIDTH];
        ovf  <= of;
      end
    end
endmodule

// File: doc/pipe_prefix_adder.md
PIPE_PREFIX_ADDER -- requirements
Module: pipe_prefix_adder

Interface
REQ-001 Parameter WIDTH, default 16, is the operand and sum width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter STAGES, default 2, is the number of register stages from input to output; legal values are 1 to 4.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: the input operands are valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an input transaction this cycle.
REQ-007 Port a, input, WIDTH bits: operand A.
REQ-008 Port b, input, WIDTH bits: operand B.
REQ-009 Port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-010 Port sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-011 Port sat, input, 1 bit: request for a signed-saturating result (see Configuration).
REQ-012 Port out_valid, output, 1 bit: the result is valid.
REQ-013 Port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-014 Port sum, output, WIDTH bits: the result.
REQ-015 Port c, output, WIDTH+1 bits: carry vector; c[0] is the effective carry-in and c[i+1] is the carry out of bit i.
REQ-016 Port cout, output, 1 bit: equal to c[WIDTH].
REQ-017 Port ovf, output, 1 bit: signed overflow, equal to c[WIDTH] XOR c[WIDTH-1].

Function
REQ-018 The carry logic SHALL be a parallel-prefix (Kogge-Stone) network with log2(WIDTH) levels.
REQ-019 Effective operands: sub=1 gives B'=~b and carry-in 1, with cin ignored; sub=0 gives B'=b and carry-in cin.
REQ-020 sum SHALL equal (a + B' + carry-in) mod 2^WIDTH, and c SHALL hold every intermediate carry.
REQ-021 Pipeline registers SHALL be spread as evenly as possible across the prefix levels; the last stage is the output register.
REQ-022 A transfer occurs on a rising edge where valid and ready are both 1, on either the input or the output side.
REQ-023 Advance condition: adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-024 When adv=1, every stage shifts forward by one; a stage loads a bubble when its upstream stage is empty or, at the input, when in_valid=0.
REQ-025 When adv=0, all stages and all outputs SHALL hold their values unchanged.
REQ-026 Latency: with no stalls, an input accepted at edge k SHALL appear with out_valid=1 after edge k+STAGES-1.
REQ-027 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-028 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-029 sum, c, cout and ovf SHALL be registered and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 Simultaneous output consume and input accept in the same cycle SHALL both complete.
REQ-031 in_valid asserted while in_ready=0 SHALL NOT be accepted; the source must hold its operands.

Reset
REQ-032 rst=1 SHALL immediately clear every stage valid bit, out_valid, sum, c, cout and ovf to 0.
REQ-033 in_ready SHALL read 1 during and after reset.
REQ-034 Reset during operation SHALL discard all in-flight transactions; the first result produced after reset comes from an input accepted after reset.

Configuration
REQ-035 Macro ADDER_SAT_EN controls saturation.
REQ-036 With ADDER_SAT_EN defined, sat=1 and ovf=1 SHALL replace sum with a saturated value: 0 followed by all ones (most positive) when a[WIDTH-1]=0, otherwise 1 followed by all zeros (most negative); c, cout and ovf are unchanged.
REQ-037 Without ADDER_SAT_EN, sat SHALL be ignored and sum SHALL always be the wrapped result; the port remains present.

Verification (WIDTH=16, STAGES=2)
REQ-038 Add zeros: a=0, b=0, cin=0, sub=0 -> sum=0x0000, c=0, cout=0, ovf=0, out_valid one cycle after acceptance.
REQ-039 Carry ripple: a=0xFFFF, b=0x0001 -> sum=0x0000, c=17'h1FFFE, cout=1, ovf=0.
REQ-040 Subtract: a=0x0005, b=0x0003, sub=1 -> sum=0x0002, cout=1, ovf=0.
REQ-041 Overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1; with ADDER_SAT_EN and sat=1 -> sum=0x7FFF, ovf=1.
REQ-042 Backpressure: stream 1+1, 2+2, 3+3 with out_ready=0 for 3 cycles -> in_ready=0 after the pipeline fills, output held at 0x0002, then 0x0002, 0x0004, 0x0006 in order once out_ready=1.
REQ-043 Reset mid-flight: assert rst with 2 transactions in flight -> out_valid=0 immediately, in_ready=1, and no stale result appears afterwards.
